// File: rtl/multicycle_control.sv
// ============================================================================
//  Module      : multicycle_control
//  Description : Moore-style main control FSM for a multicycle LEGv8 subset
//                datapath (ADD/SUB/AND/ORR, LDUR/STUR, CBZ, B). Drives the
//                datapath mux/enable controls, tracks retired instructions
//                and, optionally, traps on unrecognised opcodes.
//  Options     : define ILLEGAL_TRAP_EN to route unknown opcodes to a sticky
//                TRAP state (Illegal=1). Without it, unknown opcodes are
//                dropped and the FSM refetches; Illegal is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [10:0]      Opcode,
    input  logic             MemReady,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCSource,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             Reg2Loc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUop,
    output logic             InstrRetired,
    output logic [CNT_W-1:0] InstrCount,
    output logic             Illegal
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_EXEC_R    = 4'd3;
    localparam logic [3:0] S_EXEC_ADDR = 4'd4;
    localparam logic [3:0] S_EXEC_CBZ  = 4'd5;
    localparam logic [3:0] S_EXEC_B    = 4'd6;
    localparam logic [3:0] S_MEM_RD    = 4'd7;
    localparam logic [3:0] S_MEM_WR    = 4'd8;
    localparam logic [3:0] S_WB_R      = 4'd9;
    localparam logic [3:0] S_WB_LD     = 4'd10;
    localparam logic [3:0] S_TRAP      = 4'd11;

    // ------------------------------------------------------------------
    // Opcode patterns (instruction bits [31:21])
    // ------------------------------------------------------------------
    localparam logic [10:0] C_OP_ADD  = 11'b10001011000;
    localparam logic [10:0] C_OP_SUB  = 11'b11001011000;
    localparam logic [10:0] C_OP_AND  = 11'b10001010000;
    localparam logic [10:0] C_OP_ORR  = 11'b10101010000;
    localparam logic [10:0] C_OP_LDUR = 11'b11111000010;
    localparam logic [10:0] C_OP_STUR = 11'b11111000000;
    localparam logic [7:0]  C_OP_CBZ  = 8'b10110100;     // low 3 bits are don't-care
    localparam logic [5:0]  C_OP_B    = 6'b000101;       // low 5 bits are don't-care

    // ALU control encodings
    localparam logic [1:0] C_ALU_ADD  = 2'b00;
    localparam logic [1:0] C_ALU_PASS = 2'b01;
    localparam logic [1:0] C_ALU_RTYP = 2'b10;

    // ALUSrcB selections
    localparam logic [1:0] C_B_REG    = 2'b00;
    localparam logic [1:0] C_B_FOUR   = 2'b01;
    localparam logic [1:0] C_B_IMM    = 2'b10;
    localparam logic [1:0] C_B_BROFS  = 2'b11;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic             w_retire;
    logic             r_retired;
    logic [CNT_W-1:0] r_count;

    logic w_is_rtype;
    logic w_is_ldur;
    logic w_is_stur;
    logic w_is_cbz;
    logic w_is_b;
    logic w_is_known;

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    assign w_is_rtype = (Opcode == C_OP_ADD) || (Opcode == C_OP_SUB) ||
                        (Opcode == C_OP_AND) || (Opcode == C_OP_ORR);
    assign w_is_ldur  = (Opcode == C_OP_LDUR);
    assign w_is_stur  = (Opcode == C_OP_STUR);
    assign w_is_cbz   = (Opcode[10:3] == C_OP_CBZ);
    assign w_is_b     = (Opcode[10:5] == C_OP_B);
    assign w_is_known = w_is_rtype || w_is_ldur || w_is_stur || w_is_cbz || w_is_b;

    // State register: asynchronous reset drops straight into IDLE
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus detection of retiring transitions into FETCH
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                if (MemReady) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_is_rtype) begin
                    w_next = S_EXEC_R;
                end else if (w_is_ldur || w_is_stur) begin
                    w_next = S_EXEC_ADDR;
                end else if (w_is_cbz) begin
                    w_next = S_EXEC_CBZ;
                end else if (w_is_b) begin
                    w_next = S_EXEC_B;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = S_TRAP;
`else
                    // Unknown opcode is silently dropped: refetch, no retire
                    w_next = S_FETCH;
`endif
                end
            end
            S_EXEC_R: begin
                w_next = S_WB_R;
            end
            S_EXEC_ADDR: begin
                if (w_is_ldur) begin
                    w_next = S_MEM_RD;
                end else if (w_is_stur) begin
                    w_next = S_MEM_WR;
                end else begin
                    // Opcode changed under us; abandon without retiring
                    w_next = S_FETCH;
                end
            end
            S_EXEC_CBZ: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_EXEC_B: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_MEM_RD: begin
                if (MemReady) begin
                    w_next = S_WB_LD;
                end
            end
            S_MEM_WR: begin
                if (MemReady) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_WB_R: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_WB_LD: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                // Sticky until Reset
                w_next = S_TRAP;
`else
                // Unreachable in this build; recover cleanly if ever entered
                w_next = S_IDLE;
`endif
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Control outputs decoded from the current state (MemReady gates the IR/PC latch in FETCH)
    always_comb begin
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = C_B_REG;
        ALUop       = C_ALU_ADD;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcA = 1'b0;
                ALUSrcB = C_B_FOUR;
                ALUop   = C_ALU_ADD;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded
                ALUSrcA = 1'b0;
                ALUSrcB = C_B_BROFS;
                ALUop   = C_ALU_ADD;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = C_B_REG;
                ALUop   = C_ALU_RTYP;
            end
            S_EXEC_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = C_B_IMM;
                ALUop   = C_ALU_ADD;
            end
            S_EXEC_CBZ: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = C_B_REG;
                ALUop       = C_ALU_PASS;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            S_EXEC_B: begin
                PCWrite  = 1'b1;
                PCSource = 1'b1;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
            end
            S_WB_R: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b0;
            end
            S_WB_LD: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            default: begin
                // IDLE and TRAP keep every control low
            end
        endcase
    end

    // Reg2Loc selects Rt as the second read register for STUR/CBZ in any active state
    always_comb begin
        Reg2Loc = 1'b0;
        if ((r_state != S_IDLE) && (r_state != S_TRAP)) begin
            Reg2Loc = w_is_stur || w_is_cbz;
        end
    end

    // Retire pulse and wrapping retired-instruction counter
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_retired <= 1'b0;
            r_count   <= '0;
        end else begin
            r_retired <= w_retire;
            if (w_retire) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign InstrRetired = r_retired;
    assign InstrCount   = r_count;

`ifdef ILLEGAL_TRAP_EN
    assign Illegal = (r_state == S_TRAP);
`else
    assign Illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter: CNT_W, default 32, width of retired-instruction counter.
REQ-002 SHALL have port: CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: Opcode  input  11  instruction bits [31:21] from instruction register, valid from DECODE onward.
REQ-005 SHALL have port: MemReady  input  1  memory handshake, access completes on a cycle with MemReady=1.
REQ-006 SHALL have ports (output, 1 bit each): IRWrite, PCWrite, PCWriteCond, PCSource, MemRead, MemWrite, RegWrite, MemtoReg, Reg2Loc, ALUSrcA.
REQ-007 SHALL have ports: ALUSrcB  output  2, ALUop  output  2 (ALU control encoding: 00 add, 01 pass/zero-test, 10 R-type).
REQ-008 SHALL have ports: InstrRetired  output  1  one-cycle retire pulse; InstrCount  output  CNT_W  retired count; Illegal  output  1  trap flag.

Function
REQ-009 SHALL implement Moore FSM states IDLE, FETCH, DECODE, EXEC_R, EXEC_ADDR, EXEC_CBZ, EXEC_B, MEM_RD, MEM_WR, WB_R, WB_LD, TRAP.
REQ-010 SHALL drive every control output 0 in any state/condition not listed below.
REQ-011 IDLE: all outputs 0; SHALL go to FETCH unconditionally on the next edge.
REQ-012 FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUop=00; IRWrite=PCWrite=1 only while MemReady=1; SHALL hold while MemReady=0, go to DECODE when MemReady=1.
REQ-013 DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target); next state by Opcode: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC_R; LDUR 11111000010, STUR 11111000000 -> EXEC_ADDR; CBZ 10110100xxx -> EXEC_CBZ; B 000101xxxxx -> EXEC_B; other -> REQ-025.
REQ-014 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUop=10; -> WB_R.
REQ-015 EXEC_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00; -> MEM_RD if LDUR, MEM_WR if STUR.
REQ-016 EXEC_CBZ: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=1; -> FETCH (retire).
REQ-017 EXEC_B: PCWrite=1, PCSource=1; -> FETCH (retire).
REQ-018 MEM_RD: MemRead=1; hold while MemReady=0; -> WB_LD when MemReady=1.
REQ-019 MEM_WR: MemWrite=1; hold while MemReady=0; -> FETCH (retire) when MemReady=1.
REQ-020 WB_R: RegWrite=1, MemtoReg=0; -> FETCH (retire). WB_LD: RegWrite=1, MemtoReg=1; -> FETCH (retire).
REQ-021 Reg2Loc SHALL be 1 in every non-IDLE state whenever Opcode matches STUR or CBZ, else 0.
REQ-022 InstrRetired SHALL be registered, asserted for exactly the one cycle following each retire transition into FETCH.
REQ-023 InstrCount SHALL increment by 1 on each retire edge, wrapping from 2^CNT_W-1 to 0 with no flag.
REQ-024 Instruction latency (MemReady tied 1): R-type 4 cycles, LDUR 5, STUR 4, CBZ 3, B 3, FETCH to FETCH.

Reset
REQ-026 Reset assertion SHALL immediately force state IDLE, InstrCount 0, InstrRetired 0, Illegal 0, all control outputs 0, independent of CLK.
REQ-027 Reset mid-access (FETCH/MEM_RD/MEM_WR) SHALL abort without retire; MemWrite SHALL deassert asynchronously.
REQ-028 After deassertion, first rising edge SHALL enter FETCH.

Configuration
REQ-025 With macro ILLEGAL_TRAP_EN defined: unrecognized Opcode in DECODE SHALL go to TRAP, Illegal=1, all other outputs 0, held until Reset, no retire. Without it: DECODE SHALL go to FETCH with no retire, TRAP unreachable, Illegal tied 0 (port kept).

Verification
REQ-029 Reset pulse, MemReady=1, Opcode=ADD 10001011000 -> IDLE,FETCH,DECODE,EXEC_R,WB_R; RegWrite=1 in WB_R; InstrCount 0->1; one InstrRetired pulse.
REQ-030 LDUR 11111000010, MemReady low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, MemRead=1 throughout, WB_LD MemtoReg=1, total 8 cycles.
REQ-031 FETCH with MemReady=0 2 cycles -> IRWrite/PCWrite stay 0 until MemReady=1 cycle, then exactly one cycle high.
REQ-032 STUR 11111000000, Reset asserted during MEM_WR -> MemWrite 0 same cycle, InstrCount 0, restart via IDLE.
REQ-033 CNT_W=4, 16 CBZ 10110100000 instructions -> InstrCount wraps 15->0; Reg2Loc=1, PCWriteCond=1 in EXEC_CBZ.
REQ-034 Opcode 11111111111: with ILLEGAL_TRAP_EN -> TRAP, Illegal=1 persists 10 cycles; without -> back to FETCH, InstrCount unchanged.
